// File: rtl/mini_alu_pkg.sv
// Shared definitions for the Mini-ALU stages.
//   ALU_W        default datapath width; it must match the add/subtract stage.
//   OP_*         2-bit operation encoding. Bit 0 selects subtract and bit 1
//                marks a chained (carry/borrow-in) operation.
//   seq_state_t  issue/retire sequencer states.
package mini_alu_pkg;

   localparam int ALU_W = 6;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_ADC = 2'b10;
   localparam logic [1:0] OP_SBB = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      PASS1 = 2'b01,
      PASS2 = 2'b10,
      DONE  = 2'b11
   } seq_state_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational flag generation for the Mini-ALU.
// Ports:
//   x_sign, y_sign  in  sign bits of the registered operands
//   op_sub          in  1 = subtract-class op (SUB/SBB)
//   res             in  W-bit final result
//   c1, c2          in  carry-out of pass 1 / pass 2 (c2 = identity value
//                       when the second pass is skipped)
//   cf              out carry (add ops) or borrow (sub ops)
//   ovf             out signed overflow
//   zero            out result == 0
//   neg             out result MSB
module alu_flag_gen #(
   parameter int W = 6
) (
   input  logic         x_sign,
   input  logic         y_sign,
   input  logic         op_sub,
   input  logic [W-1:0] res,
   input  logic         c1,
   input  logic         c2,
   output logic         cf,
   output logic         ovf,
   output logic         zero,
   output logic         neg
);

   logic res_sign;

   assign res_sign = res[W-1];

   // The adder reports "no borrow" as carry-out = 1, so a borrow happened
   // when either pass lacked a carry-out.
   assign cf   = op_sub ? ~(c1 & c2) : (c1 | c2);

   // Overflow is judged on the original operands against the final result,
   // so it stays correct across the +1 / -1 second pass.
   assign ovf  = op_sub ? ((x_sign != y_sign) & (res_sign != x_sign))
                        : ((x_sign == y_sign) & (res_sign != x_sign));

   assign zero = (res == '0);
   assign neg  = res_sign;

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue/retire sequencer placed in front of the Mini-ALU add/subtract stage.
// Accepts one op over in_valid/in_ready, drives the external adder for one or
// two passes, then holds a registered result plus flags over out_valid/out_ready.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid, in_ready            request handshake (in_ready high only in IDLE)
//   in_op, in_x, in_y             op (ADD/SUB/ADC/SBB) and operands
//   add_x, add_y, add_sel         registered adder operands / subtract select
//   add_sum, add_cout             adder result and carry-out (1 = no borrow)
//   out_valid, out_ready          result handshake
//   out_res, out_cf, out_ovf,
//   out_zero, out_neg             registered result and flags
// Build option: define MINI_ALU_CARRY_CHAIN_EN to enable ADC/SBB chaining with
// a stored carry flag. Without it ADC decodes as ADD, SBB as SUB, and the
// second adder pass does not exist.
import mini_alu_pkg::*;

module alu_op_sequencer #(
   parameter int W = ALU_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   in_op,
   input  logic [W-1:0] in_x,
   input  logic [W-1:0] in_y,
   output logic [W-1:0] add_x,
   output logic [W-1:0] add_y,
   output logic         add_sel,
   input  logic [W-1:0] add_sum,
   input  logic         add_cout,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_res,
   output logic         out_cf,
   output logic         out_ovf,
   output logic         out_zero,
   output logic         out_neg
);

   seq_state_t state;
   logic       op_sub_q;
   logic       x_sign_q;
   logic       y_sign_q;
   logic       take_pass2;
   logic       go_done;
   logic       fin_c1;
   logic       fin_c2;
   logic       fg_cf;
   logic       fg_ovf;
   logic       fg_zero;
   logic       fg_neg;

`ifdef MINI_ALU_CARRY_CHAIN_EN
   logic       chain_q;
   logic       c1_q;
   logic       cf_q;

   assign take_pass2 = (state == PASS1) & chain_q & cf_q;
   assign go_done    = ((state == PASS1) & ~take_pass2) | (state == PASS2);
   assign fin_c1     = (state == PASS2) ? c1_q : add_cout;
   // A skipped second pass contributes the identity: no carry, no borrow.
   assign fin_c2     = (state == PASS2) ? add_cout : op_sub_q;
`else
   assign take_pass2 = 1'b0;
   assign go_done    = (state == PASS1);
   assign fin_c1     = add_cout;
   assign fin_c2     = op_sub_q;
`endif

   assign in_ready = (state == IDLE);

   alu_flag_gen #(.W(W)) u_flag_gen (
      .x_sign (x_sign_q),
      .y_sign (y_sign_q),
      .op_sub (op_sub_q),
      .res    (add_sum),
      .c1     (fin_c1),
      .c2     (fin_c2),
      .cf     (fg_cf),
      .ovf    (fg_ovf),
      .zero   (fg_zero),
      .neg    (fg_neg)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         op_sub_q  <= 1'b0;
         x_sign_q  <= 1'b0;
         y_sign_q  <= 1'b0;
         add_x     <= '0;
         add_y     <= '0;
         add_sel   <= 1'b0;
         out_valid <= 1'b0;
         out_res   <= '0;
         out_cf    <= 1'b0;
         out_ovf   <= 1'b0;
         out_zero  <= 1'b0;
         out_neg   <= 1'b0;
`ifdef MINI_ALU_CARRY_CHAIN_EN
         chain_q   <= 1'b0;
         c1_q      <= 1'b0;
         cf_q      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_sub_q <= in_op[0];
                  x_sign_q <= in_x[W-1];
                  y_sign_q <= in_y[W-1];
                  add_x    <= in_x;
                  add_y    <= in_y;
                  add_sel  <= in_op[0];
`ifdef MINI_ALU_CARRY_CHAIN_EN
                  chain_q  <= in_op[1];
`endif
                  state    <= PASS1;
               end
            end
            PASS1: begin
`ifdef MINI_ALU_CARRY_CHAIN_EN
               c1_q <= add_cout;
               if (take_pass2) begin
                  // Second pass applies the stored carry/borrow as +1/-1.
                  add_x <= add_sum;
                  add_y <= W'(1);
                  state <= PASS2;
               end
`endif
            end
`ifdef MINI_ALU_CARRY_CHAIN_EN
            PASS2: ;
`endif
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // Final pass: load result/flags and park the adder inputs at zero.
         if (go_done) begin
            state     <= DONE;
            add_x     <= '0;
            add_y     <= '0;
            add_sel   <= 1'b0;
            out_valid <= 1'b1;
            out_res   <= add_sum;
            out_cf    <= fg_cf;
            out_ovf   <= fg_ovf;
            out_zero  <= fg_zero;
            out_neg   <= fg_neg;
`ifdef MINI_ALU_CARRY_CHAIN_EN
            cf_q      <= fg_cf;
`endif
         end
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 6-bit adder.
// Expected values follow the build option MINI_ALU_CARRY_CHAIN_EN.
module tb_alu_op_sequencer;

   localparam int W = 6;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [1:0]   in_op = 2'b00;
   logic [W-1:0] in_x = '0;
   logic [W-1:0] in_y = '0;
   logic [W-1:0] add_x;
   logic [W-1:0] add_y;
   logic         add_sel;
   logic [W-1:0] add_sum;
   logic         add_cout;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_res;
   logic         out_cf;
   logic         out_ovf;
   logic         out_zero;
   logic         out_neg;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // Adder model: subtract is x + ~y + 1, carry-out 1 means no borrow.
   always_comb begin
      logic [W:0] t;
      t = '0;
      if (add_sel) t = {1'b0, add_x} + {1'b0, ~add_y} + (W+1)'(1);
      else         t = {1'b0, add_x} + {1'b0, add_y};
      add_sum  = t[W-1:0];
      add_cout = t[W];
   end

   alu_op_sequencer #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_x      (in_x),
      .in_y      (in_y),
      .add_x     (add_x),
      .add_y     (add_y),
      .add_sel   (add_sel),
      .add_sum   (add_sum),
      .add_cout  (add_cout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .out_cf    (out_cf),
      .out_ovf   (out_ovf),
      .out_zero  (out_zero),
      .out_neg   (out_neg)
   );

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic [W-1:0] res;
      logic         cf;
      logic         ovf;
      logic         zero;
      logic         neg;
      int           lat;
   } vec_t;

   localparam int NV = 12;
   vec_t vec [NV];

   task automatic chk(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Waits (bounded) for out_valid; returns cycles elapsed since accept.
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 8) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) begin
         n_checks++;
         n_fail++;
         $display("FAIL out_valid_timeout: got 0, expected 1 within 8 cycles");
      end
   endtask

   // Issues one op from IDLE (called at posedge+1), checks result, retires it.
   task automatic run_op(input vec_t v, input string tag);
      int lat;
      in_valid = 1'b1; in_op = v.op; in_x = v.x; in_y = v.y;
      chk({tag, "_in_ready_idle"}, in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk({tag, "_pass1_add_x"}, add_x, v.x);
      chk({tag, "_pass1_add_y"}, add_y, v.y);
      chk({tag, "_pass1_add_sel"}, add_sel, v.op[0]);
      wait_valid(lat);
      chk({tag, "_latency"}, lat, v.lat);
      chk({tag, "_res"}, out_res, v.res);
      chk({tag, "_cf"}, out_cf, v.cf);
      chk({tag, "_ovf"}, out_ovf, v.ovf);
      chk({tag, "_zero"}, out_zero, v.zero);
      chk({tag, "_neg"}, out_neg, v.neg);
      chk({tag, "_in_ready_busy"}, in_ready, 0);
      chk({tag, "_done_add_x"}, add_x, 0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_retired_valid"}, out_valid, 0);
      chk({tag, "_retired_in_ready"}, in_ready, 1);
   endtask

   initial begin
      int lat;
      vec_t v;

      //            op     x      y      res    cf ovf zr ng lat
      vec[0]  = '{2'b00, 6'h1F, 6'h01, 6'h20, 1, 1, 0, 1, 1};
      vec[0].cf = 1'b0;
      vec[1]  = '{2'b01, 6'h05, 6'h07, 6'h3E, 1, 0, 0, 1, 1};
      vec[2]  = '{2'b00, 6'h3F, 6'h01, 6'h00, 1, 0, 1, 0, 1};
`ifdef MINI_ALU_CARRY_CHAIN_EN
      vec[3]  = '{2'b10, 6'h02, 6'h03, 6'h06, 0, 0, 0, 0, 2};
`else
      vec[3]  = '{2'b10, 6'h02, 6'h03, 6'h05, 0, 0, 0, 0, 1};
`endif
      vec[4]  = '{2'b01, 6'h00, 6'h01, 6'h3F, 1, 0, 0, 1, 1};
`ifdef MINI_ALU_CARRY_CHAIN_EN
      vec[5]  = '{2'b11, 6'h00, 6'h00, 6'h3F, 1, 0, 0, 1, 2};
      vec[6]  = '{2'b10, 6'h1F, 6'h00, 6'h20, 0, 1, 0, 1, 2};
`else
      vec[5]  = '{2'b11, 6'h00, 6'h00, 6'h00, 0, 0, 1, 0, 1};
      vec[6]  = '{2'b10, 6'h1F, 6'h00, 6'h1F, 0, 0, 0, 0, 1};
`endif
      vec[7]  = '{2'b01, 6'h20, 6'h01, 6'h1F, 0, 1, 0, 0, 1};
      vec[8]  = '{2'b10, 6'h3F, 6'h3F, 6'h3E, 1, 0, 0, 1, 1};
`ifdef MINI_ALU_CARRY_CHAIN_EN
      vec[9]  = '{2'b11, 6'h10, 6'h05, 6'h0A, 0, 0, 0, 0, 2};
`else
      vec[9]  = '{2'b11, 6'h10, 6'h05, 6'h0B, 0, 0, 0, 0, 1};
`endif
      vec[10] = '{2'b00, 6'h3F, 6'h3F, 6'h3E, 1, 0, 0, 1, 1};
`ifdef MINI_ALU_CARRY_CHAIN_EN
      vec[11] = '{2'b10, 6'h3F, 6'h00, 6'h00, 1, 0, 1, 0, 2};
`else
      vec[11] = '{2'b10, 6'h3F, 6'h00, 6'h3F, 0, 0, 0, 1, 1};
`endif

      // Reset state
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_res", out_res, 0);
      chk("rst_add_x", add_x, 0);
      chk("rst_add_sel", add_sel, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // out_ready while idle has no effect
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("idle_ready_out_valid", out_valid, 0);
      chk("idle_ready_in_ready", in_ready, 1);

      for (int i = 0; i < NV; i++) run_op(vec[i], $sformatf("v%0d", i));

      // Back-pressure: result held for 5 cycles with out_ready low
      in_valid = 1'b1; in_op = 2'b00; in_x = 6'h10; in_y = 6'h10;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid(lat);
      chk("stall_latency", lat, 1);
      for (int c = 0; c < 5; c++) begin
         chk("stall_valid", out_valid, 1);
         chk("stall_res", out_res, 6'h20);
         chk("stall_flags", {out_cf, out_ovf, out_zero, out_neg}, 4'b0101);
         chk("stall_in_ready", in_ready, 0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("stall_retire_in_ready", in_ready, 1);
      chk("stall_retire_valid", out_valid, 0);

      // Reset in the middle of a chained op (PASS1 when chaining is absent)
      run_op(vec[2], "pre_rst");
      in_valid = 1'b1; in_op = 2'b10; in_x = 6'h02; in_y = 6'h03;
      @(posedge clk); #1;
      in_valid = 1'b0;
`ifdef MINI_ALU_CARRY_CHAIN_EN
      @(posedge clk); #1;
      chk("pass2_add_x", add_x, 6'h05);
      chk("pass2_add_y", add_y, 6'h01);
`endif
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_add", {add_x, add_y, add_sel}, 0);
      chk("midrst_out_res", out_res, 0);
      chk("midrst_flags", {out_cf, out_ovf, out_zero, out_neg}, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("postrst_valid", out_valid, 0);
      v = '{2'b00, 6'h01, 6'h01, 6'h02, 0, 0, 0, 0, 1};
      run_op(v, "postrst_add");
      // Stored carry cleared by reset, so ADC stays single-pass
      v = '{2'b10, 6'h01, 6'h01, 6'h02, 0, 0, 0, 0, 1};
      run_op(v, "postrst_adc");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1);
   end

endmodule
